// File: rtl/imem_window_if.sv
// imem_window_if
//   Fetch / program-load bus between the PC-fetch logic (master) and the
//   instruction store (slave).
//   Signals:
//     en, stall, addr        fetch request, stall hold, window base address
//     we, waddr, wdata       program-load write port
//     win_data, valid, oob   registered fetch window and its status flags
interface imem_window_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int WINDOW = 3
);
  logic                     en;
  logic                     stall;
  logic [ADDR_W-1:0]        addr;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [WINDOW*DATA_W-1:0] win_data;
  logic                     valid;
  logic                     oob;

  modport master (
    output en, stall, addr, we, waddr, wdata,
    input  win_data, valid, oob
  );

  modport slave (
    input  en, stall, addr, we, waddr, wdata,
    output win_data, valid, oob
  );
endinterface

// File: rtl/imem_window.sv
// imem_window
//   Instruction store with a registered multi-word fetch window. An accepted
//   fetch returns WINDOW consecutive words starting at addr one cycle later.
//   Also provides a program-load write port, a stall hold, a valid flag and
//   out-of-range detection for window words beyond DEPTH.
//   Ports:
//     clock    in   rising-edge clock
//     reset_n  in   synchronous active-low reset (clears outputs, not memory)
//     bus      slave modport of imem_window_if (fetch + write + outputs)
//   Build option:
//     IMEM_FWD_EN  when defined, a write hitting a window index on the same
//                  edge as the fetch returns the new data in that slice;
//                  otherwise the slice returns the pre-write contents.
module imem_window #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  parameter int WINDOW = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  imem_window_if.slave bus
);

  localparam int LP_XW = ADDR_W + 4;
  localparam int LP_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LP_XW-1:0] LP_DEPTH_X = LP_XW'(DEPTH);

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [WINDOW*DATA_W-1:0] r_win_data;
  logic                     r_valid;
  logic                     r_oob;

  // Indices are computed four bits wider than the address so that a window
  // starting near the top of the address space never wraps back to zero.
  logic [LP_XW-1:0]         w_idx [WINDOW];
  logic [LP_XW-1:0]         w_waddr_x;
  logic                     w_wr_ok;
  logic                     w_fetch;
  logic [WINDOW*DATA_W-1:0] w_next_data;
  logic                     w_next_oob;

  assign w_waddr_x = {4'b0000, bus.waddr};
  assign w_wr_ok   = bus.we && (w_waddr_x < LP_DEPTH_X);
  assign w_fetch   = bus.en && !bus.stall;

  always_comb begin
    w_next_data = '0;
    w_next_oob  = 1'b0;
    for (int k = 0; k < WINDOW; k++) begin
      w_idx[k] = {4'b0000, bus.addr} + LP_XW'(k);
      if (w_idx[k] < LP_DEPTH_X) begin
        w_next_data[k*DATA_W +: DATA_W] = r_mem[w_idx[k][LP_AW-1:0]];
`ifdef IMEM_FWD_EN
        if (w_wr_ok && (w_waddr_x == w_idx[k])) begin
          w_next_data[k*DATA_W +: DATA_W] = bus.wdata;
        end
`endif
      end else begin
        w_next_oob = 1'b1;
      end
    end
  end

  // Storage has no reset: program contents survive a core reset.
  always_ff @(posedge clock) begin
    if (reset_n && w_wr_ok) begin
      r_mem[w_waddr_x[LP_AW-1:0]] <= bus.wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_win_data <= '0;
      r_valid    <= 1'b0;
      r_oob      <= 1'b0;
    end else if (w_fetch) begin
      r_win_data <= w_next_data;
      r_valid    <= 1'b1;
      r_oob      <= w_next_oob;
    end else if (!bus.stall) begin
      // Idle edge: drop the flags, keep the last window visible.
      r_valid <= 1'b0;
      r_oob   <= 1'b0;
    end
  end

  assign bus.win_data = r_win_data;
  assign bus.valid    = r_valid;
  assign bus.oob      = r_oob;

endmodule

// File: tb/tb_imem_window.sv
module tb_imem_window;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DP = 256;
  localparam int WN = 3;

  logic clock;
  logic reset_n;

  imem_window_if #(.DATA_W(DW), .ADDR_W(AW), .WINDOW(WN)) bus ();

  imem_window #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .WINDOW(WN)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef IMEM_FWD_EN
  localparam logic [31:0] FWD_S0 = 32'h0B;
`else
  localparam logic [31:0] FWD_S0 = 32'h0A;
`endif

  typedef struct {
    logic          rst_n;
    logic          we;
    logic [31:0]   waddr;
    logic [31:0]   wdata;
    logic          en;
    logic          stall;
    logic [31:0]   addr;
    logic [95:0]   exp_data;
    logic          exp_valid;
    logic          exp_oob;
  } vec_t;

  vec_t vecs [$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] wa,
                              input logic [31:0] wd, input logic e, input logic s,
                              input logic [31:0] a, input logic [95:0] xd,
                              input logic xv, input logic xo);
    vec_t v;
    v.rst_n = r; v.we = w; v.waddr = wa; v.wdata = wd;
    v.en = e; v.stall = s; v.addr = a;
    v.exp_data = xd; v.exp_valid = xv; v.exp_oob = xo;
    return v;
  endfunction

  function automatic logic [95:0] w3(input logic [31:0] s2, input logic [31:0] s1,
                                     input logic [31:0] s0);
    return {s2, s1, s0};
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clock);
    reset_n   = v.rst_n;
    bus.we    = v.we;
    bus.waddr = v.waddr;
    bus.wdata = v.wdata;
    bus.en    = v.en;
    bus.stall = v.stall;
    bus.addr  = v.addr;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [95:0] xd, input logic xv,
                       input logic xo);
    total++;
    if (bus.win_data !== xd || bus.valid !== xv || bus.oob !== xo) begin
      bad++;
      $display("FAIL %s: got data=%h valid=%b oob=%b, want data=%h valid=%b oob=%b",
               name, bus.win_data, bus.valid, bus.oob, xd, xv, xo);
    end
  endtask

  logic [31:0] model [8];

  initial begin
    reset_n = 1'b0; bus.we = 0; bus.waddr = 0; bus.wdata = 0;
    bus.en = 0; bus.stall = 0; bus.addr = 0;

    //               rst we waddr   wdata   en st addr    exp_data                       v  o
    // reset with fetch requested
    vecs.push_back(mk(0, 0, 0,      0,      1, 0, 0,      '0,                            0, 0));
    vecs.push_back(mk(0, 0, 0,      0,      1, 0, 0,      '0,                            0, 0));
    // program load
    vecs.push_back(mk(1, 1, 0,      32'h10, 0, 0, 0,      '0,                            0, 0));
    vecs.push_back(mk(1, 1, 1,      32'h11, 0, 0, 0,      '0,                            0, 0));
    vecs.push_back(mk(1, 1, 2,      32'h12, 0, 0, 0,      '0,                            0, 0));
    vecs.push_back(mk(1, 1, 3,      32'h13, 0, 0, 0,      '0,                            0, 0));
    vecs.push_back(mk(1, 1, 4,      32'h14, 0, 0, 0,      '0,                            0, 0));
    // fetch addr 2
    vecs.push_back(mk(1, 1, 254,    32'hFE, 1, 0, 2,      w3(32'h14, 32'h13, 32'h12),     1, 0));
    // idle edge: flags drop, data holds
    vecs.push_back(mk(1, 1, 255,    32'hFF, 0, 0, 0,      w3(32'h14, 32'h13, 32'h12),     0, 0));
    vecs.push_back(mk(1, 1, 44,     32'h44, 0, 0, 0,      w3(32'h14, 32'h13, 32'h12),     0, 0));
    vecs.push_back(mk(1, 1, 45,     32'h45, 0, 0, 0,      w3(32'h14, 32'h13, 32'h12),     0, 0));
    vecs.push_back(mk(1, 1, 46,     32'h46, 0, 0, 0,      w3(32'h14, 32'h13, 32'h12),     0, 0));
    // out-of-range write dropped (300 must not alias to 44), fetch across the end
    vecs.push_back(mk(1, 1, 300,    32'hDEAD, 1, 0, 254,  w3(32'h00, 32'hFF, 32'hFE),     1, 1));
    vecs.push_back(mk(1, 0, 0,      0,      1, 0, 44,     w3(32'h46, 32'h45, 32'h44),     1, 0));
    vecs.push_back(mk(1, 0, 0,      0,      1, 0, 255,    w3(32'h00, 32'h00, 32'hFF),     1, 1));
    vecs.push_back(mk(1, 0, 0,      0,      1, 0, 32'hFFFFFFFF, '0,                       1, 1));
    vecs.push_back(mk(1, 0, 0,      0,      0, 0, 0,      '0,                            0, 0));
    // preload 5..7
    vecs.push_back(mk(1, 1, 5,      32'h0A, 0, 0, 0,      '0,                            0, 0));
    vecs.push_back(mk(1, 1, 6,      32'h66, 0, 0, 0,      '0,                            0, 0));
    vecs.push_back(mk(1, 1, 7,      32'h77, 0, 0, 0,      '0,                            0, 0));
    // stall sequence
    vecs.push_back(mk(1, 0, 0,      0,      1, 0, 0,      w3(32'h12, 32'h11, 32'h10),     1, 0));
    vecs.push_back(mk(1, 0, 0,      0,      1, 1, 4,      w3(32'h12, 32'h11, 32'h10),     1, 0));
    vecs.push_back(mk(1, 0, 0,      0,      1, 1, 4,      w3(32'h12, 32'h11, 32'h10),     1, 0));
    vecs.push_back(mk(1, 0, 0,      0,      1, 1, 4,      w3(32'h12, 32'h11, 32'h10),     1, 0));
    vecs.push_back(mk(1, 0, 0,      0,      1, 0, 4,      w3(32'h66, 32'h0A, 32'h14),     1, 0));
    // forwarding: write and fetch same index on one edge
    vecs.push_back(mk(1, 1, 5,      32'h0B, 1, 0, 5,      w3(32'h77, 32'h66, FWD_S0),     1, 0));
    // write during stall still lands
    vecs.push_back(mk(1, 1, 7,      32'h70, 0, 1, 0,      w3(32'h77, 32'h66, FWD_S0),     1, 0));
    vecs.push_back(mk(1, 0, 0,      0,      1, 0, 5,      w3(32'h70, 32'h66, 32'h0B),     1, 0));
    // reset mid-stream; write during reset ignored
    vecs.push_back(mk(1, 0, 0,      0,      1, 0, 0,      w3(32'h12, 32'h11, 32'h10),     1, 0));
    vecs.push_back(mk(0, 1, 0,      32'hBAD, 1, 0, 1,     '0,                            0, 0));
    vecs.push_back(mk(1, 0, 0,      0,      1, 0, 1,      w3(32'h13, 32'h12, 32'h11),     1, 0));
    vecs.push_back(mk(1, 0, 0,      0,      1, 0, 0,      w3(32'h12, 32'h11, 32'h10),     1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_oob);
    end

    // Back-to-back fetches at full rate against a small contents model.
    model[0] = 32'h10; model[1] = 32'h11; model[2] = 32'h12; model[3] = 32'h13;
    model[4] = 32'h14; model[5] = 32'h0B; model[6] = 32'h66; model[7] = 32'h70;
    for (int a = 0; a < 6; a++) begin
      vec_t v;
      v = mk(1, 0, 0, 0, 1, 0, a, '0, 1, 0);
      drive(v);
      check($sformatf("b2b_addr%0d", a), w3(model[a+2], model[a+1], model[a]), 1'b1, 1'b0);
    end

    // Stall after idle keeps valid low; release accepts the presented fetch.
    drive(mk(1, 0, 0, 0, 0, 0, 0, '0, 0, 0));
    check("idle_before_stall", w3(model[7], model[6], model[5]), 1'b0, 1'b0);
    drive(mk(1, 0, 0, 0, 1, 1, 3, '0, 0, 0));
    check("stall_over_idle", w3(model[7], model[6], model[5]), 1'b0, 1'b0);
    drive(mk(1, 0, 0, 0, 1, 0, 3, '0, 0, 0));
    check("stall_release", w3(model[5], model[4], model[3]), 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
